// File: rtl/vco_pll_cfg_if.sv
// vco_pll_cfg_if: control handshake plus synthesizer 3-wire and lock-detect pins of the LO sequencer
interface vco_pll_cfg_if #(parameter int NUM_REGS = 6);
    logic                   start;
    logic [NUM_REGS*32-1:0] cfg_regs;
    logic                   busy;
    logic                   done;
    logic                   locked;
    logic                   lock_err;
    logic                   VCO_CE;
    logic                   VCO_CLK;
    logic                   VCO_DATA;
    logic                   VCO_LE;
    logic                   VCO_LD;
    modport master (
        output start, cfg_regs, VCO_LD,
        input  busy, done, locked, lock_err, VCO_CE, VCO_CLK, VCO_DATA, VCO_LE
    );
    modport slave (
        input  start, cfg_regs, VCO_LD,
        output busy, done, locked, lock_err, VCO_CE, VCO_CLK, VCO_DATA, VCO_LE
    );
endinterface

// File: rtl/vco_pll_cfg.sv
// vco_pll_cfg: serial programming of the LO synthesizer register bank followed by lock qualification
module vco_pll_cfg #(
    parameter int NUM_REGS     = 6,
    parameter int CLK_DIV      = 10,
    parameter int LOCK_HOLD    = 16,
    parameter int LOCK_TIMEOUT = 50000
) (
    input logic          clk,
    input logic          rst_n,
    vco_pll_cfg_if.slave bus
);
    localparam int W  = NUM_REGS * 32;
    localparam int CW = $clog2(CLK_DIV + 1);
    localparam int RW = $clog2(NUM_REGS + 1);
    localparam int HW = $clog2(LOCK_HOLD + 1);
    localparam int TW = $clog2(LOCK_TIMEOUT + 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
    localparam logic [HW-1:0] HOLD_N   = HW'(LOCK_HOLD);
    localparam logic [TW-1:0] TMO_N    = TW'(LOCK_TIMEOUT);
    typedef enum logic [2:0] {IDLE, SHIFT, LATCH, GAP, WAIT_LOCK} state_t;
    state_t        state, state_d;
    logic [W-1:0]  shadow, shadow_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [4:0]    bit_cnt, bit_cnt_d;
    logic [RW-1:0] idx, idx_d;
    logic [HW-1:0] hold, hold_d, hold_nx;
    logic [TW-1:0] tmo, tmo_d, tmo_nx;
    logic          ld_s1, ld_s2, div_end;
    logic          busy_d, done_d, locked_d, err_d, ce_d, sclk_d, sdata_d, le_d;
    assign div_end = cnt == DIV_LAST;
    assign hold_nx = ld_s2 ? hold + 1'b1 : '0;
    assign tmo_nx  = tmo + 1'b1;
    // shadow is a left-shifting image: its MSB is always the next bit on the wire
    always_comb begin
        state_d   = state;
        shadow_d  = shadow;
        cnt_d     = div_end ? '0 : cnt + 1'b1;
        bit_cnt_d = bit_cnt;
        idx_d     = idx;
        hold_d    = hold;
        tmo_d     = tmo;
        busy_d    = bus.busy;
        done_d    = 1'b0;
        locked_d  = bus.locked;
        err_d     = bus.lock_err;
        ce_d      = bus.VCO_CE;
        sclk_d    = bus.VCO_CLK;
        sdata_d   = bus.VCO_DATA;
        le_d      = bus.VCO_LE;
        case (state)
            IDLE: begin
                locked_d = bus.locked & ld_s2;
                if (bus.start) begin
                    state_d   = SHIFT;
                    shadow_d  = bus.cfg_regs << 1;
                    sdata_d   = bus.cfg_regs[W-1];
                    cnt_d     = '0;
                    bit_cnt_d = '0;
                    idx_d     = RW'(NUM_REGS - 1);
                    busy_d    = 1'b1;
                    ce_d      = 1'b1;
                    locked_d  = 1'b0;
                    err_d     = 1'b0;
                end
            end
            SHIFT: begin
                if (div_end && !bus.VCO_CLK) sclk_d = 1'b1;
                else if (div_end) begin
                    sclk_d = 1'b0;
                    if (bit_cnt == 5'd31) begin
                        state_d = LATCH;
                        sdata_d = 1'b0;
                        le_d    = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt + 1'b1;
                        sdata_d   = shadow[W-1];
                        shadow_d  = shadow << 1;
                    end
                end
            end
            LATCH: begin
                if (div_end) begin
                    le_d    = 1'b0;
                    state_d = GAP;
                end
            end
            GAP: begin
                if (div_end && idx != '0) begin
                    state_d   = SHIFT;
                    idx_d     = idx - 1'b1;
                    bit_cnt_d = '0;
                    sdata_d   = shadow[W-1];
                    shadow_d  = shadow << 1;
                end else if (div_end) begin
                    state_d = WAIT_LOCK;
                    hold_d  = '0;
                    tmo_d   = '0;
                end
            end
            WAIT_LOCK: begin
                hold_d = hold_nx;
                tmo_d  = tmo_nx;
                if (hold_nx == HOLD_N || tmo_nx == TMO_N) begin
                    state_d  = IDLE;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    locked_d = hold_nx == HOLD_N;
                    err_d    = hold_nx != HOLD_N;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            shadow       <= '0;
            cnt          <= '0;
            bit_cnt      <= '0;
            idx          <= '0;
            hold         <= '0;
            tmo          <= '0;
            ld_s1        <= 1'b0;
            ld_s2        <= 1'b0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.locked   <= 1'b0;
            bus.lock_err <= 1'b0;
            bus.VCO_CE   <= 1'b0;
            bus.VCO_CLK  <= 1'b0;
            bus.VCO_DATA <= 1'b0;
            bus.VCO_LE   <= 1'b0;
        end else begin
            state        <= state_d;
            shadow       <= shadow_d;
            cnt          <= cnt_d;
            bit_cnt      <= bit_cnt_d;
            idx          <= idx_d;
            hold         <= hold_d;
            tmo          <= tmo_d;
            ld_s1        <= bus.VCO_LD;
            ld_s2        <= ld_s1;
            bus.busy     <= busy_d;
            bus.done     <= done_d;
            bus.locked   <= locked_d;
            bus.lock_err <= err_d;
            bus.VCO_CE   <= ce_d;
            bus.VCO_CLK  <= sclk_d;
            bus.VCO_DATA <= sdata_d;
            bus.VCO_LE   <= le_d;
        end
    end
endmodule

// File: tb/tb_vco_pll_cfg.sv
// tb_vco_pll_cfg: directed checks of shift order, LE framing, lock qualification, timeout and reset
module tb_vco_pll_cfg;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;
    vco_pll_cfg_if #(.NUM_REGS(2)) bus ();
    vco_pll_cfg #(.NUM_REGS(2), .CLK_DIV(2), .LOCK_HOLD(16), .LOCK_TIMEOUT(100)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );
    int passes, checks, now, nbits, le_pulses, le_w, le_bad, glitches, dones, t_le_fall;
    int t0, t1, b_bits, b_le, b_done;
    logic [63:0] rx;
    logic sclk_q, data_q, le_q;
    function automatic logic [7:0] outs();
        return {bus.busy, bus.done, bus.locked, bus.lock_err,
                bus.VCO_CE, bus.VCO_CLK, bus.VCO_DATA, bus.VCO_LE};
    endfunction
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask
    // one clock, sampled on the falling edge; tracks wire-level events of the serial port
    task automatic tick();
        @(negedge clk);
        now++;
        if (bus.VCO_CLK && !sclk_q) begin
            rx = {rx[62:0], bus.VCO_DATA};
            nbits++;
        end
        if (bus.VCO_CLK && sclk_q && bus.VCO_DATA !== data_q) glitches++;
        if (bus.VCO_LE) le_w++;
        if (!bus.VCO_LE && le_q) begin
            le_pulses++;
            if (le_w != 2) le_bad++;
            le_w = 0;
            t_le_fall = now;
        end
        if (bus.done) dones++;
        sclk_q = bus.VCO_CLK;
        data_q = bus.VCO_DATA;
        le_q   = bus.VCO_LE;
    endtask
    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask
    task automatic wait_le(input int target, input int max);
        for (int n = 0; n < max && le_pulses < target; n++) tick();
    endtask
    task automatic wait_done(input int max);
        for (int n = 0; n < max && !bus.done; n++) tick();
    endtask
    initial begin
        sclk_q = 1'b0;
        data_q = 1'b0;
        le_q   = 1'b0;
        rx     = '0;
        rst_n        = 1'b0;
        bus.start    = 1'b1;
        bus.VCO_LD   = 1'b1;
        bus.cfg_regs = 64'hA5A50001_00008005;
        repeat (4) tick();
        check("reset_outs", 64'(outs()), 64'h0);
        bus.start  = 1'b0;
        bus.VCO_LD = 1'b0;
        rst_n      = 1'b1;
        repeat (6) tick();
        check("idle_no_start", 64'(outs()), 64'h0);
        // first sequence: register 1 then register 0, MSB first
        b_bits = nbits;
        b_le   = le_pulses;
        pulse_start();
        t0 = now;
        check("start_busy_ce_data", 64'({bus.busy, bus.VCO_CE, bus.VCO_CLK, bus.VCO_DATA}), 64'b1101);
        for (int n = 0; n < 20 && !bus.VCO_CLK; n++) tick();
        check("first_sclk_rise", 64'(now - t0), 64'd2);
        wait_le(b_le + 2, 400);
        check("last_le_fall", 64'(t_le_fall - t0), 64'd262);
        check("shift_data", rx, 64'hA5A50001_00008005);
        check("shift_bits", 64'(nbits - b_bits), 64'd64);
        check("le_pulses", 64'(le_pulses - b_le), 64'd2);
        check("le_width_bad", 64'(le_bad), 64'd0);
        check("data_glitch", 64'(glitches), 64'd0);
        check("busy_in_wait", 64'(bus.busy), 64'd1);
        while (now < t0 + 270) tick();
        bus.VCO_LD = 1'b1;
        t1 = now;
        wait_done(100);
        check("lock_latency", 64'(now - t1), 64'd18);
        check("lock_flags", 64'({bus.done, bus.busy, bus.locked, bus.lock_err}), 64'b1010);
        tick();
        check("done_one_cycle", 64'({bus.done, bus.locked}), 64'b01);
        bus.VCO_LD = 1'b0;
        repeat (3) tick();
        check("unlock_in_idle", 64'(bus.locked), 64'd0);
        // no lock indication at all: timeout path
        pulse_start();
        t0 = now;
        wait_done(500);
        check("timeout_latency", 64'(now - t0), 64'd364);
        check("timeout_flags", 64'({bus.done, bus.busy, bus.locked, bus.lock_err}), 64'b1001);
        tick();
        check("err_holds_idle", 64'({bus.done, bus.lock_err}), 64'b01);
        // short LD glitch must not qualify; steady LD later must
        pulse_start();
        t0 = now;
        check("start_clears_err", 64'({bus.busy, bus.lock_err}), 64'b10);
        while (now < t0 + 270) tick();
        b_done = dones;
        bus.VCO_LD = 1'b1;
        repeat (10) tick();
        bus.VCO_LD = 1'b0;
        repeat (8) tick();
        check("glitch_no_done", 64'(dones - b_done), 64'd0);
        check("glitch_no_lock", 64'({bus.locked, bus.busy}), 64'b01);
        bus.VCO_LD = 1'b1;
        t1 = now;
        wait_done(100);
        check("relock_latency", 64'(now - t1), 64'd18);
        check("relock_flags", 64'({bus.locked, bus.lock_err}), 64'b10);
        // repeated start and cfg change mid-shift are ignored
        bus.VCO_LD   = 1'b0;
        bus.cfg_regs = 64'h12345678_9ABCDEF0;
        b_bits = nbits;
        b_le   = le_pulses;
        pulse_start();
        t0 = now;
        repeat (20) tick();
        bus.cfg_regs = 64'hFFFF0000_0000FFFF;
        pulse_start();
        wait_le(b_le + 2, 400);
        check("restart_data", rx, 64'h12345678_9ABCDEF0);
        check("restart_bits", 64'(nbits - b_bits), 64'd64);
        wait_done(500);
        check("restart_single_seq", 64'(now - t0), 64'd364);
        check("restart_le_pulses", 64'(le_pulses - b_le), 64'd2);
        // asynchronous reset mid-shift, then a clean retransmission
        bus.cfg_regs = 64'hDEADBEEF_0F0F0F0F;
        pulse_start();
        repeat (40) tick();
        b_le  = le_pulses;
        rst_n = 1'b0;
        #1;
        check("async_reset_outs", 64'(outs()), 64'h0);
        repeat (3) tick();
        check("reset_no_le", 64'(le_pulses - b_le), 64'd0);
        rst_n = 1'b1;
        tick();
        b_bits = nbits;
        b_le   = le_pulses;
        pulse_start();
        t0 = now;
        wait_le(b_le + 2, 400);
        check("after_reset_data", rx, 64'hDEADBEEF_0F0F0F0F);
        check("after_reset_bits", 64'(nbits - b_bits), 64'd64);
        wait_done(500);
        check("after_reset_timeout", 64'(now - t0), 64'd364);
        check("final_le_width_bad", 64'(le_bad), 64'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/vco_pll_cfg.md
# vco_pll_cfg

Serial configuration sequencer for the receiver's local-oscillator synthesizer (VCO/PLL with 3-wire CE/CLK/DATA/LE interface and lock-detect output). On a start request it captures a bank of 32-bit register images, shifts them out MSB-first, highest register index first, latches each with an LE pulse, then waits for a qualified lock indication. It sits between the tuning/control logic and the `VCO_*` board pins of the `sdr` top level.

## Interface

- `NUM_REGS`, 6, number of synthesizer registers written per sequence
- `CLK_DIV`, 10, `clk` cycles per `VCO_CLK` half-period (min 1)
- `LOCK_HOLD`, 16, consecutive synchronized-high `VCO_LD` cycles required to declare lock (min 1)
- `LOCK_TIMEOUT`, 50000, `clk` cycles allowed in lock wait before error

- `clk` in 1 system clock
- `rst_n` in 1 asynchronous, active-low reset
- `start` in 1 single-cycle request; honoured only when idle
- `cfg_regs` in `NUM_REGS*32` register images; index i at bits `[32*i+31:32*i]`
- `busy` out 1 high from accepted start until `done`
- `done` out 1 one-cycle pulse at end of sequence (lock or timeout)
- `locked` out 1 qualified lock status
- `lock_err` out 1 lock timeout flag for the last sequence
- `VCO_CE` out 1 synthesizer chip enable
- `VCO_CLK` out 1 serial clock
- `VCO_DATA` out 1 serial data
- `VCO_LE` out 1 load enable
- `VCO_LD` in 1 asynchronous lock detect from synthesizer

## Operation

- Reset (async): state IDLE; all outputs 0; shadow, counters cleared.
- States: IDLE, SHIFT, LATCH, GAP, WAIT_LOCK.
- IDLE: `start`=1 → copy `cfg_regs` to shadow, reg index = `NUM_REGS-1`, bit count 0, `busy`=1, `VCO_CE`=1, clear `locked` and `lock_err`, go SHIFT. `start` in any other state ignored; `cfg_regs` changes after capture have no effect.
- `VCO_CE` stays 1 once set until reset.
- SHIFT: each bit = `CLK_DIV` cycles `VCO_CLK`=0 then `CLK_DIV` cycles `VCO_CLK`=1; `VCO_DATA` changes only at bit start (while `VCO_CLK` low), held stable through the high phase. Bit order 31..0 of current register. After bit 0 high phase → LATCH with `VCO_CLK`=0.
- LATCH: `VCO_LE`=1 for `CLK_DIV` cycles, `VCO_CLK`=0, `VCO_DATA`=0.
- GAP: `VCO_LE`=0 for `CLK_DIV` cycles. Then if reg index > 0: decrement, go SHIFT; else go WAIT_LOCK.
- WAIT_LOCK: `VCO_LD` through 2-FF synchronizer; hold counter increments while synced LD=1, clears when 0. Counter reaching `LOCK_HOLD` → `locked`=1, `done` pulse, IDLE. Timeout counter reaching `LOCK_TIMEOUT` first → `lock_err`=1, `done` pulse, IDLE. If both on the same cycle, lock wins.
- `busy` falls on the cycle `done` is high.
- In IDLE after a successful lock, `locked` clears the first cycle synced LD=0 and stays clear until the next sequence qualifies lock; `lock_err` holds until next accepted start.

## Timing

- `start` at edge k → `busy`, `VCO_CE`, first `VCO_DATA` valid from k+1; first `VCO_CLK` rise at k+1+`CLK_DIV`.
- Per register: 64·`CLK_DIV` (shift) + `CLK_DIV` (LE) + `CLK_DIV` (gap) = 66·`CLK_DIV` cycles; defaults 660, full bank 3960 cycles before WAIT_LOCK.
- Lock qualification: ≥ 2 (sync) + `LOCK_HOLD` cycles after `VCO_LD` rises.
- Reset mid-sequence: outputs 0 immediately, no partial LE pulse; next start restarts from top register.
- All outputs registered; no combinational path from inputs to outputs.

## Test plan

- Reset: hold `rst_n`=0 with `VCO_LD`=1, `start`=1 → all outputs 0, `busy`=0; release, no start → remains idle.
- `NUM_REGS`=2, `CLK_DIV`=2, `cfg_regs`={0xA5A50001, 0x00008005}, pulse `start` → bench samples `VCO_DATA` on `VCO_CLK` rise: 0xA5A50001 then 0x00008005; exactly 2 LE pulses, each 2 cycles; WAIT_LOCK entered 264 cycles after start.
- Continue above with `VCO_LD`=1, `LOCK_HOLD`=16 → `locked`=1 and `done` pulse 18–19 cycles after LD high; `busy` falls with `done`; then drop LD → `locked`=0 within 3 cycles.
- `VCO_LD`=0 throughout, `LOCK_TIMEOUT`=100 → `lock_err`=1, `done` pulse, `locked`=0; next `start` clears `lock_err`.
- LD glitch high 10 cycles then low, `LOCK_HOLD`=16 → no lock; later steady high → lock declared.
- `start` re-pulsed mid-SHIFT and `cfg_regs` changed → shifted bits unchanged, single sequence; `rst_n` pulsed mid-shift → outputs 0, new start retransmits from top register.
